// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_unit_pkg;

    localparam int X_LENGTH = 32;
    localparam int INST_BYTES = 4;
    localparam logic [X_LENGTH-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [X_LENGTH-1:0] MISALIGN_VECTOR = 32'h0000_001C;

    typedef enum logic [2:0] {
        PC_SEL_SEQ,
        PC_SEL_HOLD,
        PC_SEL_REDIRECT,
        PC_SEL_TRAP,
        PC_SEL_MISALIGN
    } pc_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority encoder choosing the source of the next PC:
// trap, then redirect (aligned or misaligned), then stall, then sequential.
module pc_next_sel
    import pc_unit_pkg::*;
(
    input  logic       trap_valid,
    input  logic       redirect_valid,
    input  logic [1:0] redirect_lsb,
    input  logic       stall,
    output pc_sel_t    sel
);

    always_comb begin
        sel = PC_SEL_SEQ;
        if (trap_valid) begin
            sel = PC_SEL_TRAP;
        end else if (redirect_valid) begin
            sel = (redirect_lsb == 2'b00) ? PC_SEL_REDIRECT : PC_SEL_MISALIGN;
        end else if (stall) begin
            sel = PC_SEL_HOLD;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter generator feeding the fetch stage, tracking which PC the
// one-cycle-latency ROM output belongs to and whether it is on the correct path.
module pc_unit #(
    parameter int                   X_LENGTH        = pc_unit_pkg::X_LENGTH,
    parameter logic [X_LENGTH-1:0]  RESET_VECTOR    = pc_unit_pkg::RESET_VECTOR,
    parameter logic [X_LENGTH-1:0]  MISALIGN_VECTOR = pc_unit_pkg::MISALIGN_VECTOR
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [X_LENGTH-1:0] pc,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [X_LENGTH-1:0] redirect_target,
    input  logic                trap_valid,
    input  logic [X_LENGTH-1:0] trap_vector,
    output logic [X_LENGTH-1:0] inst_pc,
    output logic                inst_valid,
    output logic                misaligned,
    output logic [X_LENGTH-1:0] misaligned_addr,
    output logic [31:0]         fetch_count
);

    import pc_unit_pkg::*;

    localparam logic [X_LENGTH-1:0] STEP       = X_LENGTH'(INST_BYTES);
    localparam logic [X_LENGTH-1:0] ALIGN_MASK = ~(X_LENGTH'(INST_BYTES - 1));

    pc_sel_t sel;

    logic [X_LENGTH-1:0] pc_q, pc_d;
    logic [X_LENGTH-1:0] inst_pc_q, inst_pc_d;
    logic                inst_valid_q, inst_valid_d;
    logic                misaligned_q, misaligned_d;
    logic [X_LENGTH-1:0] misaligned_addr_q, misaligned_addr_d;
    logic [31:0]         fetch_count_q, fetch_count_d;

    pc_next_sel u_sel (
        .trap_valid     (trap_valid),
        .redirect_valid (redirect_valid),
        .redirect_lsb   (redirect_target[1:0]),
        .stall          (stall),
        .sel            (sel)
    );

    always_comb begin
        pc_d              = pc_q + STEP;
        misaligned_d      = 1'b0;
        misaligned_addr_d = misaligned_addr_q;
        case (sel)
            PC_SEL_TRAP:     pc_d = trap_vector & ALIGN_MASK;
            PC_SEL_REDIRECT: pc_d = redirect_target;
            PC_SEL_MISALIGN: begin
                pc_d              = MISALIGN_VECTOR;
                misaligned_d      = 1'b1;
                misaligned_addr_d = redirect_target;
            end
            PC_SEL_HOLD:     pc_d = pc_q;
            default:         pc_d = pc_q + STEP;
        endcase

        // ROM reads every cycle, so the next output always belongs to the current pc.
        inst_pc_d = pc_q;
        // A stall re-presents the same instruction; a redirect/trap kills the one in flight.
        inst_valid_d = (sel == PC_SEL_HOLD) ? inst_valid_q : ~(trap_valid | redirect_valid);

        fetch_count_d = fetch_count_q;
        if (inst_valid_q && !stall && !trap_valid && !redirect_valid) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q              <= RESET_VECTOR;
            inst_pc_q         <= '0;
            inst_valid_q      <= 1'b0;
            misaligned_q      <= 1'b0;
            misaligned_addr_q <= '0;
            fetch_count_q     <= '0;
        end else begin
            pc_q              <= pc_d;
            inst_pc_q         <= inst_pc_d;
            inst_valid_q      <= inst_valid_d;
            misaligned_q      <= misaligned_d;
            misaligned_addr_q <= misaligned_addr_d;
            fetch_count_q     <= fetch_count_d;
        end
    end

    assign pc              = pc_q;
    assign inst_pc         = inst_pc_q;
    assign inst_valid      = inst_valid_q;
    assign misaligned      = misaligned_q;
    assign misaligned_addr = misaligned_addr_q;
    assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        misaligned;
    logic [31:0] misaligned_addr;
    logic [31:0] fetch_count;

    int n_cmp;
    int n_bad;

    pc_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc              (pc),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .misaligned      (misaligned),
        .misaligned_addr (misaligned_addr),
        .fetch_count     (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_iv,
                             input logic [31:0] e_ipc, input logic [31:0] e_fc);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, e_iv});
        chk({tag, ".inst_pc"}, inst_pc, e_ipc);
        chk({tag, ".fetch_count"}, fetch_count, e_fc);
        $display("step %-12s pc=%08h inst_pc=%08h iv=%0b mis=%0b maddr=%08h fc=%0d",
                 tag, pc, inst_pc, inst_valid, misaligned, misaligned_addr, fetch_count);
    endtask

    task automatic chk_mis(input string tag, input logic e_mis, input logic [31:0] e_addr);
        chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, e_mis});
        chk({tag, ".misaligned_addr"}, misaligned_addr, e_addr);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        trap_valid = 1'b0;
        trap_vector = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk_state("reset", 32'h0, 1'b0, 32'h0, 32'd0);
        chk_mis("reset", 1'b0, 32'h0);
        #1 rst_n = 1'b1;

        // Reset release, three sequential cycles
        chk_state("rel0", 32'h0, 1'b0, 32'h0, 32'd0);
        tick(); chk_state("seq1", 32'h4, 1'b1, 32'h0, 32'd0);
        tick(); chk_state("seq2", 32'h8, 1'b1, 32'h4, 32'd1);
        tick(); chk_state("seq3", 32'hC, 1'b1, 32'h8, 32'd2);

        // Get back to pc=8 with a valid instruction, then stall
        redirect_valid = 1'b1; redirect_target = 32'h4;
        tick(); chk_state("redir4", 32'h4, 1'b0, 32'hC, 32'd2);
        redirect_valid = 1'b0;
        tick(); chk_state("seq8", 32'h8, 1'b1, 32'h4, 32'd2);
        stall = 1'b1;
        tick(); chk_state("stall1", 32'h8, 1'b1, 32'h8, 32'd2);
        tick(); chk_state("stall2", 32'h8, 1'b1, 32'h8, 32'd2);
        tick(); chk_state("stall3", 32'h8, 1'b1, 32'h8, 32'd2);
        stall = 1'b0;
        tick(); chk_state("unstall", 32'hC, 1'b1, 32'h8, 32'd3);

        // Aligned redirect from pc=0x10
        tick(); chk_state("seq10", 32'h10, 1'b1, 32'hC, 32'd4);
        redirect_valid = 1'b1; redirect_target = 32'h40;
        tick(); chk_state("redir40", 32'h40, 1'b0, 32'h10, 32'd4);
        redirect_valid = 1'b0;
        tick(); chk_state("post40", 32'h44, 1'b1, 32'h40, 32'd4);
        chk_mis("post40", 1'b0, 32'h0);

        // Misaligned redirect, single then back-to-back
        redirect_valid = 1'b1; redirect_target = 32'h42;
        tick(); chk_state("mis42", 32'h1C, 1'b0, 32'h44, 32'd4);
        chk_mis("mis42", 1'b1, 32'h42);
        redirect_valid = 1'b0;
        tick(); chk_state("post42", 32'h20, 1'b1, 32'h1C, 32'd4);
        chk_mis("post42", 1'b0, 32'h42);
        redirect_valid = 1'b1; redirect_target = 32'h41;
        tick(); chk_mis("mis41", 1'b1, 32'h41);
        chk("mis41.pc", pc, 32'h1C);
        redirect_target = 32'h43;
        tick(); chk_mis("mis43", 1'b1, 32'h43);
        redirect_valid = 1'b0;
        tick(); chk_state("post43", 32'h20, 1'b1, 32'h1C, 32'd4);
        chk_mis("post43", 1'b0, 32'h43);

        // Trap beats redirect and stall; vector low bits are dropped
        trap_valid = 1'b1; trap_vector = 32'h23;
        redirect_valid = 1'b1; redirect_target = 32'h80;
        stall = 1'b1;
        tick(); chk_state("trap", 32'h20, 1'b0, 32'h20, 32'd4);
        chk_mis("trap", 1'b0, 32'h43);
        trap_valid = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        tick(); chk_state("posttrap", 32'h24, 1'b1, 32'h20, 32'd4);

        // Trap with a misaligned redirect alongside: no misaligned event
        trap_valid = 1'b1; trap_vector = 32'h100;
        redirect_valid = 1'b1; redirect_target = 32'h81;
        tick(); chk("trapmis.pc", pc, 32'h100);
        chk_mis("trapmis", 1'b0, 32'h43);
        trap_valid = 1'b0; redirect_valid = 1'b0;

        // Wrap at the top of the address space
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick(); chk_state("redirtop", 32'hFFFF_FFFC, 1'b0, 32'h100, 32'd4);
        redirect_valid = 1'b0;
        tick(); chk_state("wrap", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'd4);
        tick(); chk_state("postwrap", 32'h4, 1'b1, 32'h0, 32'd5);

        // Asynchronous reset in the middle of a redirect cycle
        redirect_valid = 1'b1; redirect_target = 32'h200;
        #3 rst_n = 1'b0;
        #1 chk_state("midrst", 32'h0, 1'b0, 32'h0, 32'd0);
        chk_mis("midrst", 1'b0, 32'h0);
        redirect_valid = 1'b0;
        tick(); chk_state("inrst", 32'h0, 1'b0, 32'h0, 32'd0);
        #1 rst_n = 1'b1;
        tick(); chk_state("rst_seq1", 32'h4, 1'b1, 32'h0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
